// File: rtl/key_filter_multi.sv
// key_filter_multi: N-channel push-button debouncer.
// Each channel has a two-flop synchroniser, a restart-on-bounce debounce
// counter, a debounced level, one-cycle press/release strobes and a
// one-shot long-press strobe. All channels are independent and share clk.
module key_filter_multi #(
    parameter int N           = 4,
    parameter int DB_CYCLES   = 1_000_000,
    parameter int LONG_CYCLES = 50_000_000,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] key_in,
    output logic [N-1:0] key_out,
    output logic [N-1:0] key_press,
    output logic [N-1:0] key_release,
    output logic [N-1:0] key_long
);

    localparam int DB_W   = $clog2(DB_CYCLES);
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_ZERO   = DB_W'(0);
    localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ZERO = HOLD_W'(0);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);

    // Pressed level on the pins and the matching idle vector.
    localparam logic         PRESSED_LVL = ACTIVE_LOW ? 1'b0 : 1'b1;
    localparam logic         IDLE_LVL    = ~PRESSED_LVL;
    localparam logic [N-1:0] IDLE_VEC    = {N{IDLE_LVL}};

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_WAIT = 2'd1,
        HELD       = 2'd2,
        REL_WAIT   = 2'd3
    } state_t;

    logic [N-1:0]      sync1_r;
    logic [N-1:0]      sync2_r;
    logic [N-1:0]      act_s;
    state_t            state_r    [N];
    logic [DB_W-1:0]   db_cnt_r   [N];
    logic [HOLD_W-1:0] hold_cnt_r [N];
    logic [HOLD_W-1:0] hold_next_s[N];
    logic [N-1:0]      long_fire_s;

    // Two-flop synchroniser; resets to the idle level so no press is seen on reset exit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_r <= IDLE_VEC;
            sync2_r <= IDLE_VEC;
        end else begin
            sync1_r <= key_in;
            sync2_r <= sync1_r;
        end
    end

    // Normalise the synchronised pins to "key is at the pressed level".
    always_comb begin
        act_s = sync2_r;
        if (ACTIVE_LOW) begin
            act_s = ~sync2_r;
        end else begin
            act_s = sync2_r;
        end
    end

    // Saturating hold counter step; flags the single cycle it reaches LONG_CYCLES.
    always_comb begin
        long_fire_s = '0;
        for (int i = 0; i < N; i++) begin
            hold_next_s[i] = hold_cnt_r[i];
            if (hold_cnt_r[i] == HOLD_FIRE) begin
                hold_next_s[i] = HOLD_MAX;
                long_fire_s[i] = 1'b1;
            end else if (hold_cnt_r[i] < HOLD_MAX) begin
                hold_next_s[i] = hold_cnt_r[i] + HOLD_ONE;
            end else begin
                hold_next_s[i] = hold_cnt_r[i];
            end
        end
    end

    // Per-channel debounce FSM with registered level and strobe outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_out     <= IDLE_VEC;
            key_press   <= '0;
            key_release <= '0;
            key_long    <= '0;
            for (int i = 0; i < N; i++) begin
                state_r[i]    <= IDLE;
                db_cnt_r[i]   <= DB_ZERO;
                hold_cnt_r[i] <= HOLD_ZERO;
            end
        end else begin
            // Strobes default low; individual channels raise theirs below.
            key_press   <= '0;
            key_release <= '0;
            key_long    <= '0;
            for (int i = 0; i < N; i++) begin
                case (state_r[i])
                    IDLE: begin
                        hold_cnt_r[i] <= HOLD_ZERO;
                        if (act_s[i]) begin
                            state_r[i]  <= PRESS_WAIT;
                            db_cnt_r[i] <= DB_ONE;
                        end else begin
                            db_cnt_r[i] <= DB_ZERO;
                        end
                    end
                    PRESS_WAIT: begin
                        if (!act_s[i]) begin
                            // Bounce: the stable run starts over from nothing.
                            state_r[i]  <= IDLE;
                            db_cnt_r[i] <= DB_ZERO;
                        end else if (db_cnt_r[i] == DB_LAST) begin
                            state_r[i]    <= HELD;
                            db_cnt_r[i]   <= DB_ZERO;
                            hold_cnt_r[i] <= HOLD_ZERO;
                            key_out[i]    <= PRESSED_LVL;
                            key_press[i]  <= 1'b1;
                        end else begin
                            db_cnt_r[i] <= db_cnt_r[i] + DB_ONE;
                        end
                    end
                    HELD: begin
                        hold_cnt_r[i] <= hold_next_s[i];
                        key_long[i]   <= long_fire_s[i];
                        if (!act_s[i]) begin
                            state_r[i]  <= REL_WAIT;
                            db_cnt_r[i] <= DB_ONE;
                        end else begin
                            db_cnt_r[i] <= DB_ZERO;
                        end
                    end
                    REL_WAIT: begin
                        if (act_s[i]) begin
                            // Release bounce: back to HELD, hold time keeps running.
                            state_r[i]    <= HELD;
                            db_cnt_r[i]   <= DB_ZERO;
                            hold_cnt_r[i] <= hold_next_s[i];
                            key_long[i]   <= long_fire_s[i];
                        end else if (db_cnt_r[i] == DB_LAST) begin
                            // Accepted release wins over a coincident long strobe.
                            state_r[i]     <= IDLE;
                            db_cnt_r[i]    <= DB_ZERO;
                            hold_cnt_r[i]  <= HOLD_ZERO;
                            key_out[i]     <= IDLE_LVL;
                            key_release[i] <= 1'b1;
                        end else begin
                            db_cnt_r[i]   <= db_cnt_r[i] + DB_ONE;
                            hold_cnt_r[i] <= hold_next_s[i];
                            key_long[i]   <= long_fire_s[i];
                        end
                    end
                    default: begin
                        state_r[i]    <= IDLE;
                        db_cnt_r[i]   <= DB_ZERO;
                        hold_cnt_r[i] <= HOLD_ZERO;
                        key_out[i]    <= IDLE_LVL;
                    end
                endcase
            end
        end
    end

endmodule
